// File: rtl/cache_fill_fsm.sv
// cache_fill_fsm
// Miss-handling controller between a direct-mapped cache and a 16-bit
// pipelined main memory. On a miss it issues eight back-to-back word reads
// covering the 16-byte block, writes each returned word into the data array
// in arrival order, strobes the tag array with the last word, then pulses
// fill_done for one cycle before returning to IDLE.

module cache_fill_fsm #(
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  miss_detected,
  input  logic [ADDR_WIDTH-1:0] miss_address,
  input  logic                  memory_data_valid,
  input  logic [15:0]           memory_data,
  output logic                  fsm_busy,
  output logic                  mem_enable,
  output logic [ADDR_WIDTH-1:0] memory_address,
  output logic                  write_data_array,
  output logic [2:0]            word_offset,
  output logic [15:0]           cache_wdata,
  output logic                  write_tag_array,
  output logic                  fill_done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] base;       // 16-byte aligned block address
  logic [3:0]            issue_cnt;  // requests issued so far, saturates at 8
  logic [2:0]            ret_cnt;    // words returned so far (wraps after 8th)

  logic                  issuing;
  logic                  returning;

  // The byte offset within the block never matters: the whole block is fetched.
  logic                  unused_offset_bits;
  assign unused_offset_bits = ^miss_address[3:0];

  // Issue stops once all eight requests are out; returns count only in FILL.
  assign issuing   = (state == FILL) && !issue_cnt[3];
  assign returning = (state == FILL) && memory_data_valid;

  // State, block base and both counters. Issue and return sides advance
  // independently so returns may overlap with outstanding requests.
  // NOTE: every register here is assigned with <= so all of them sample the
  // pre-edge values; blocking = would let later statements see updated state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      base      <= '0;
      issue_cnt <= '0;
      ret_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (miss_detected) begin
            base      <= {miss_address[ADDR_WIDTH-1:4], 4'b0000};
            issue_cnt <= '0;
            ret_cnt   <= '0;
            state     <= FILL;
          end
        end
        FILL: begin
          if (issuing) begin
            issue_cnt <= issue_cnt + 4'd1;
          end
          if (returning) begin
            ret_cnt <= ret_cnt + 3'd1;
            if (ret_cnt == 3'd7) begin
              state <= DONE;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Output decode: request side from registered state only, write side
  // qualified by the incoming valid.
  // NOTE: each output gets a default before the conditional assignments so
  // no path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    fsm_busy         = 1'b0;
    mem_enable       = 1'b0;
    memory_address   = '0;
    write_data_array = 1'b0;
    word_offset      = '0;
    write_tag_array  = 1'b0;
    fill_done        = 1'b0;
    cache_wdata      = memory_data;

    if (state == FILL || state == DONE) begin
      fsm_busy = 1'b1;
    end
    if (state == DONE) begin
      fill_done = 1'b1;
    end
    if (issuing) begin
      mem_enable     = 1'b1;
      memory_address = base + {{(ADDR_WIDTH-4){1'b0}}, issue_cnt[2:0], 1'b0};
    end
    if (returning) begin
      write_data_array = 1'b1;
      word_offset      = ret_cnt;
      write_tag_array  = (ret_cnt == 3'd7);
    end
  end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Directed testbench for cache_fill_fsm. Each fill is driven cycle by cycle
// from a valid-arrival mask; expected outputs come from a small cycle model
// of the fill protocol kept in the bench.

module tb_cache_fill_fsm;

  logic        clk;
  logic        rst_n;
  logic        miss_detected;
  logic [15:0] miss_address;
  logic        memory_data_valid;
  logic [15:0] memory_data;
  logic        fsm_busy;
  logic        mem_enable;
  logic [15:0] memory_address;
  logic        write_data_array;
  logic [2:0]  word_offset;
  logic [15:0] cache_wdata;
  logic        write_tag_array;
  logic        fill_done;

  int n_vec;
  int n_err;

  cache_fill_fsm #(.ADDR_WIDTH(16)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .miss_detected     (miss_detected),
    .miss_address      (miss_address),
    .memory_data_valid (memory_data_valid),
    .memory_data       (memory_data),
    .fsm_busy          (fsm_busy),
    .mem_enable        (mem_enable),
    .memory_address    (memory_address),
    .write_data_array  (write_data_array),
    .word_offset       (word_offset),
    .cache_wdata       (cache_wdata),
    .write_tag_array   (write_tag_array),
    .fill_done         (fill_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string pfx, input int c,
                           input logic e_busy, input logic e_en, input logic [15:0] e_addr,
                           input logic e_wr, input logic [2:0] e_off, input logic e_tag,
                           input logic e_done, input logic [15:0] e_wdata);
    check($sformatf("%s c%0d busy", pfx, c),   {31'd0, fsm_busy},         {31'd0, e_busy});
    check($sformatf("%s c%0d en", pfx, c),     {31'd0, mem_enable},       {31'd0, e_en});
    check($sformatf("%s c%0d addr", pfx, c),   {16'd0, memory_address},   {16'd0, e_addr});
    check($sformatf("%s c%0d wr", pfx, c),     {31'd0, write_data_array}, {31'd0, e_wr});
    check($sformatf("%s c%0d off", pfx, c),    {29'd0, word_offset},      {29'd0, e_off});
    check($sformatf("%s c%0d tag", pfx, c),    {31'd0, write_tag_array},  {31'd0, e_tag});
    check($sformatf("%s c%0d done", pfx, c),   {31'd0, fill_done},        {31'd0, e_done});
    check($sformatf("%s c%0d wdata", pfx, c),  {16'd0, cache_wdata},      {16'd0, e_wdata});
  endtask

  // One fill, entered at the start of the IDLE cycle that samples the miss
  // (cycle 0). vmask bit c = memory_data_valid in cycle c. miss_detected is
  // dropped from drop_cyc on; during DONE it equals hold. chg swaps
  // miss_address from cycle 2 on. abort_cyc asserts rst_n mid-cycle.
  // Returns at the start of the cycle following DONE.
  task automatic run_fill(input string pfx, input logic [15:0] addr, input logic [63:0] vmask,
                          input int drop_cyc, input bit chg, input bit hold, input int abort_cyc);
    int          st;
    int          issue;
    int          nw;
    logic [15:0] b;
    logic [15:0] wd;
    logic        v;
    logic        md;
    logic        e_en;
    logic        e_wr;
    bit          fin;
    st  = 0;
    issue = 0;
    nw  = 0;
    b   = 16'h0000;
    fin = 1'b0;
    for (int c = 0; c < 60 && !fin; c++) begin
      v  = vmask[c];
      md = (st == 2) ? hold : (c < drop_cyc);
      wd = 16'hA000 ^ 16'(c * 16'h0111);
      miss_detected     = md;
      miss_address      = (chg && c >= 2) ? 16'hBEEF : addr;
      memory_data_valid = v;
      memory_data       = wd;
      if (c == abort_cyc) begin
        #2 rst_n = 1'b0;
        #1;
        check_all({pfx, " async_rst"}, c, 1'b0, 1'b0, 16'h0000, 1'b0, 3'd0, 1'b0, 1'b0, wd);
        return;
      end
      @(negedge clk);
      e_en = (st == 1) && (issue < 8);
      e_wr = (st == 1) && v;
      check_all(pfx, c, (st != 0), e_en,
                e_en ? 16'(b + 16'(2 * issue)) : 16'h0000,
                e_wr, e_wr ? 3'(nw) : 3'd0, e_wr && (nw == 7),
                (st == 2), wd);
      case (st)
        0: if (md) begin
             st    = 1;
             issue = 0;
             nw    = 0;
             b     = {addr[15:4], 4'h0};
           end
        1: begin
             if (issue < 8) issue++;
             if (v) begin
               nw++;
               if (nw == 8) st = 2;
             end
           end
        default: begin
             st  = 0;
             fin = 1'b1;
           end
      endcase
      @(posedge clk);
      #1;
    end
    if (!fin) check({pfx, " fill_timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    n_vec             = 0;
    n_err             = 0;
    rst_n             = 1'b0;
    miss_detected     = 1'b0;
    miss_address      = 16'h0000;
    memory_data_valid = 1'b0;
    memory_data       = 16'h5A5A;

    // Reset state
    #12;
    check_all("reset", 0, 1'b0, 1'b0, 16'h0000, 1'b0, 3'd0, 1'b0, 1'b0, 16'h5A5A);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic fill, latency 4: valids in cycles 5..12, fill_done in 13
    run_fill("basic", 16'h1236, 64'h0000_0000_0000_1FE0, 99, 1'b0, 1'b0, -1);
    // IDLE cycle after DONE
    miss_detected = 1'b0;
    @(negedge clk);
    check("basic idle busy", {31'd0, fsm_busy}, 32'd0);
    check("basic idle en",   {31'd0, mem_enable}, 32'd0);
    @(posedge clk);
    #1;

    // Irregular returns: valids at 3,4,7,9,10,14,15,18
    run_fill("irreg", 16'h5554, 64'h0000_0000_0004_C698, 99, 1'b0, 1'b0, -1);

    // Spurious valid in IDLE (cycle 0) and miss_address changed mid-fill
    run_fill("spur", 16'h2468, 64'h0000_0000_0000_1FE1, 99, 1'b1, 1'b0, -1);

    // Miss drops at cycle 3; also a valid during DONE (cycle 13) is ignored
    run_fill("drop", 16'h7ABC, 64'h0000_0000_0000_3FE0, 3, 1'b0, 1'b0, -1);

    // Reset at cycle 6 of a fill, then stale valids after release
    run_fill("rstmid", 16'h4000, 64'h0000_0000_0000_1FE0, 99, 1'b0, 1'b0, 6);
    #3 rst_n = 1'b1;
    miss_detected = 1'b0;
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      memory_data_valid = 1'b1;
      @(negedge clk);
      check($sformatf("stale%0d wr", k),   {31'd0, write_data_array}, 32'd0);
      check($sformatf("stale%0d tag", k),  {31'd0, write_tag_array}, 32'd0);
      check($sformatf("stale%0d busy", k), {31'd0, fsm_busy}, 32'd0);
      @(posedge clk);
      #1;
    end
    memory_data_valid = 1'b0;

    // Top-of-memory block: 0xFFF0..0xFFFE without wrap
    run_fill("top", 16'hFFF0, 64'h0000_0000_0000_1FE0, 99, 1'b0, 1'b0, -1);

    // Back-to-back: miss held through DONE, next fill starts in the IDLE cycle
    run_fill("b2b_a", 16'h1100, 64'h0000_0000_0000_1FE0, 99, 1'b0, 1'b1, -1);
    run_fill("b2b_b", 16'h220A, 64'h0000_0000_0000_1FE0, 99, 1'b0, 1'b0, -1);

    miss_detected = 1'b0;
    @(negedge clk);
    check("end busy", {31'd0, fsm_busy}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/cache_fill_fsm.md
# cache_fill_fsm

Miss-handling controller between a direct-mapped cache and the 16-bit pipelined main memory. On a cache miss it fetches the 16-byte block containing the miss address as eight word reads at a 2-byte stride. It writes each returned word into the cache data array, then updates the tag array and signals completion. One instance serves the I-cache and one serves the D-cache; an arbiter downstream of both fill FSMs selects which one drives the memory.

## Interface
- ADDR_WIDTH, 16, byte-address width. The block is always 8 words of 16 bits, so 4 offset bits.
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset. Returns all state to reset values immediately.
- miss_detected  input  1  cache lookup missed; held high by the cache until the fill completes.
- miss_address  input  ADDR_WIDTH  byte address that missed; sampled in IDLE only.
- memory_data_valid  input  1  memory returns one word this cycle.
- memory_data  input  16  returned word.
- fsm_busy  output  1  high in FILL and DONE; stalls the pipeline.
- mem_enable  output  1  read request to memory this cycle.
- memory_address  output  ADDR_WIDTH  word-aligned address of the current request.
- write_data_array  output  1  write strobe for the cache data array.
- word_offset  output  3  word index within the block for the current data-array write.
- cache_wdata  output  16  data for the data-array write; combinational pass-through of memory_data.
- write_tag_array  output  1  tag/valid write strobe; high only with the 8th data write.
- fill_done  output  1  one-cycle completion pulse.

## Operation
- States:
  - IDLE: the base register, issue_cnt (4 bits, 0..8) and ret_cnt (3 bits) are all held in this state.
  - FILL
  - DONE
- IDLE → FILL when miss_detected=1. On that edge:
  - base latches {miss_address[ADDR_WIDTH-1:4], 4'b0}.
  - issue_cnt and ret_cnt clear to 0.
- FILL, request side:
  - While issue_cnt<8: mem_enable=1 and memory_address = base + {issue_cnt[2:0],1'b0}.
  - issue_cnt increments every cycle until it reaches 8.
  - Once issue_cnt=8: mem_enable=0.
  - Addresses never wrap past the block, because base is 16-byte aligned.
- FILL, return side:
  - Each cycle with memory_data_valid=1: write_data_array=1, word_offset=ret_cnt, ret_cnt increments.
  - Returns are assumed in issue order.
- FILL → DONE on the edge after the 8th valid (ret_cnt=7 and valid). write_tag_array=1 in that same cycle as the last data write.
- DONE: fill_done=1 and fsm_busy=1 for exactly one cycle, then unconditionally → IDLE.
- mem_enable, memory_address, fsm_busy and fill_done are functions of registered state only.
- write_data_array, word_offset, write_tag_array and cache_wdata combine state with memory_data_valid.
- Boundary rules:
  - memory_data_valid in IDLE or DONE is ignored: no write strobes, no counter change.
  - miss_detected falling mid-FILL is ignored; the fill always completes all 8 words.
  - miss_address changes after the IDLE sample are ignored.
  - Valids may arrive while requests are still being issued; issue and return counters run independently.
  - A new miss is accepted only in IDLE. miss_detected high in the first IDLE cycle after DONE starts a new fill. The cache re-looks-up after fill_done, so a correctly filled block produces no spurious refill.
  - rst_n low at any time, including mid-FILL:
    - State → IDLE and counters → 0.
    - All outputs → 0 (memory_address 0).
    - Outstanding memory returns after reset are discarded by the IDLE rule.

## Timing
- Reset values:
  - fsm_busy, mem_enable, write_data_array, write_tag_array and fill_done are 0.
  - memory_address and word_offset are 0.
  - cache_wdata follows memory_data.
- Miss sampled at cycle 0 edge → requests issued cycles 1..8, one per cycle, with no bubbles.
- With memory latency L (valid L cycles after the request cycle):
  - Writes occur cycles 1+L..8+L.
  - fill_done at 9+L, IDLE at 10+L.
  - For L=4: fill_done at cycle 13.
- fsm_busy rises the cycle after the miss is sampled and falls the cycle after fill_done.

## Test plan
- Basic fill: miss_address=0x1236, L=4 model.
  - Requests 0x1230,0x1232,…,0x123E in cycles 1-8.
  - Data writes with word_offset 0..7 in cycles 5-12.
  - write_tag_array in cycle 12 only, fill_done pulse in cycle 13, IDLE in cycle 14.
- Irregular returns: valids with random gaps, 8 total.
  - Exactly 8 data writes with offsets 0..7 in order.
  - fill_done exactly one cycle after the 8th valid.
  - mem_enable still low after cycle 8.
- Spurious inputs: memory_data_valid pulsed in IDLE, and miss_address changed mid-FILL.
  - No write strobes in IDLE.
  - Block base unchanged; all 8 addresses derive from the originally sampled address.
- Miss drop: miss_detected deasserted at cycle 3. The fill still completes with 8 writes and fill_done.
- Reset mid-fill: rst_n low at cycle 6, then 3 stale valids after release.
  - All outputs 0 immediately (asynchronously).
  - Stale valids produce no writes.
  - A new miss at 0xFFF0 fills 0xFFF0..0xFFFE without address wrap.
- Back-to-back misses: miss_detected held high through DONE.
  - A second fill starts in the IDLE cycle after fill_done, with new requests beginning one cycle later.
